// File: rtl/ahb_lite_crypto_cfg_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_crypto_cfg_slave
//
// AHB-Lite configuration slave for the encryption core. The host loads key,
// nonce, destination and plain-text words over the bus. Writing the last
// plain-text word commits the block to the downstream FIFO (write_out pulse).
// While the FIFO is full, that last write is held in a wait state.
//
// Word map (byte address 4*n):
//   n = 0                        STATUS / control
//   n = 1 .. K                   key words
//   next N words                 nonce words
//   next word                    destination
//   next P words                 plain-text words (last one commits)
//
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA
//                                AHB-Lite slave inputs (HBURST ignored)
//   fifo_full                    downstream FIFO full
//   HREADYOUT, HRESP, HRDATA     AHB-Lite slave outputs
//   key, nonce, destination, plain_text
//                                configuration registers, word i at [32i+:32]
//   write_out                    one-cycle pulse: block committed to FIFO
//
// Build option:
//   CRYPTO_CFG_READBACK_EN       when defined, key and nonce words read back;
//                                otherwise they read as zero (OKAY response).
// ---------------------------------------------------------------------------
module ahb_lite_crypto_cfg_slave #(
    parameter int unsigned KEY_WORDS   = 4,
    parameter int unsigned NONCE_WORDS = 4,
    parameter int unsigned PT_WORDS    = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSELx,
    input  logic [31:0]               HADDR,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [1:0]                HTRANS,
    input  logic                      HREADY,
    input  logic [31:0]               HWDATA,
    input  logic                      fifo_full,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [31:0]               HRDATA,
    output logic [32*KEY_WORDS-1:0]   key,
    output logic [32*NONCE_WORDS-1:0] nonce,
    output logic [31:0]               destination,
    output logic [32*PT_WORDS-1:0]    plain_text,
    output logic                      write_out
);

    localparam int unsigned KEY_BASE   = 1;
    localparam int unsigned NONCE_BASE = KEY_BASE + KEY_WORDS;
    localparam int unsigned DEST_IDX   = NONCE_BASE + NONCE_WORDS;
    localparam int unsigned PT_BASE    = DEST_IDX + 1;
    localparam int unsigned PT_LAST    = PT_BASE + PT_WORDS - 1;
    localparam int unsigned NUM_WORDS  = PT_LAST + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                     state_q, state_d;
    logic [29:0]                widx_q, widx_d;
    logic                       write_q, write_d;
    logic [32*KEY_WORDS-1:0]    key_q, key_d;
    logic [32*NONCE_WORDS-1:0]  nonce_q, nonce_d;
    logic [31:0]                dest_q, dest_d;
    logic [32*PT_WORDS-1:0]     pt_q, pt_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       write_out_q, write_out_d;

    logic                       accept;
    logic                       addr_err;
    logic                       last_pt;
    logic                       store;
    logic [31:0]                status_word;
    logic                       unused_ok;

    assign unused_ok = ^{HBURST, HTRANS[0]};

    assign accept   = HSELx & HREADY & HTRANS[1];
    assign addr_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                      (HADDR[31:2] >= 30'(NUM_WORDS));
    assign last_pt  = write_q && (widx_q == 30'(PT_LAST));

    // Bus FSM. An erroneous beat goes straight to ERR1 so that its data
    // phase is the two-cycle ERROR response; a last plain-text write that
    // meets a full FIFO holds its data phase in STALL.
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        store     = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                if (last_pt && fifo_full) begin
                    HREADYOUT = 1'b0;
                    state_d   = ST_STALL;
                end else begin
                    store = write_q;
                end
            end
            ST_STALL: begin
                if (fifo_full) begin
                    HREADYOUT = 1'b0;
                end else begin
                    store = 1'b1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (HREADYOUT) begin
            if (accept) begin
                state_d = addr_err ? ST_ERR1 : ST_DATA;
                widx_d  = HADDR[31:2];
                write_d = HWRITE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Register file update on a completing write data phase.
    always_comb begin
        key_d       = key_q;
        nonce_d     = nonce_q;
        dest_d      = dest_q;
        pt_d        = pt_q;
        cnt_d       = cnt_q;
        write_out_d = 1'b0;
        if (store) begin
            if (widx_q == '0) begin
                if (HWDATA[0]) begin
                    key_d   = '0;
                    nonce_d = '0;
                    dest_d  = '0;
                    pt_d    = '0;
                    cnt_d   = '0;
                end
            end
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                if (widx_q == 30'(KEY_BASE + i)) key_d[32*i +: 32] = HWDATA;
            end
            for (int unsigned i = 0; i < NONCE_WORDS; i++) begin
                if (widx_q == 30'(NONCE_BASE + i)) nonce_d[32*i +: 32] = HWDATA;
            end
            if (widx_q == 30'(DEST_IDX)) dest_d = HWDATA;
            for (int unsigned i = 0; i < PT_WORDS; i++) begin
                if (widx_q == 30'(PT_BASE + i)) pt_d[32*i +: 32] = HWDATA;
            end
            if (widx_q == 30'(PT_LAST)) begin
                write_out_d = 1'b1;
                cnt_d       = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Read data is only driven during a non-error read data phase.
    always_comb begin
        status_word                   = '0;
        status_word[0]                = fifo_full;
        status_word[1]                = (state_q == ST_STALL);
        status_word[8 +: CNT_WIDTH]   = cnt_q;
        HRDATA                        = '0;
        if ((state_q == ST_DATA) && !write_q) begin
            if (widx_q == '0) HRDATA = status_word;
`ifdef CRYPTO_CFG_READBACK_EN
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                if (widx_q == 30'(KEY_BASE + i)) HRDATA = key_q[32*i +: 32];
            end
            for (int unsigned i = 0; i < NONCE_WORDS; i++) begin
                if (widx_q == 30'(NONCE_BASE + i)) HRDATA = nonce_q[32*i +: 32];
            end
`else
            // key/nonce addresses fall through and read as zero
`endif
            if (widx_q == 30'(DEST_IDX)) HRDATA = dest_q;
            for (int unsigned i = 0; i < PT_WORDS; i++) begin
                if (widx_q == 30'(PT_BASE + i)) HRDATA = pt_q[32*i +: 32];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            write_q     <= 1'b0;
            key_q       <= '0;
            nonce_q     <= '0;
            dest_q      <= '0;
            pt_q        <= '0;
            cnt_q       <= '0;
            write_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            write_q     <= write_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            dest_q      <= dest_d;
            pt_q        <= pt_d;
            cnt_q       <= cnt_d;
            write_out_q <= write_out_d;
        end
    end

    assign key         = key_q;
    assign nonce       = nonce_q;
    assign destination = dest_q;
    assign plain_text  = pt_q;
    assign write_out   = write_out_q;

endmodule
